gpio_in_filter: RTL and testbench
=================================

GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

Interface
REQ-001 SHALL have parameter IOWidth, default 36, meaning the number of input pins handled.
REQ-002 SHALL have parameter FiltWidth, default 8, meaning the width of the filter length and of each per-pin counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port pin_in, input, IOWidth bits: raw pin levels, sourced from the data_from_gpio output of the bidir pin block.
REQ-006 SHALL have port filt_len, input, FiltWidth bits: number of extra stable ticks required before a new level is accepted.
REQ-007 SHALL have port prescale, input, 16 bits: tick divider, used only when the configuration feature is compiled in.
REQ-008 SHALL have port rise_ena, input, IOWidth bits: per-pin enable for rising-edge events.
REQ-009 SHALL have port fall_ena, input, IOWidth bits: per-pin enable for falling-edge events.
REQ-010 SHALL have port irq_mask, input, IOWidth bits: per-pin interrupt enable.
REQ-011 SHALL have port event_clr, input, IOWidth bits: write-1-to-clear strobe for the event flags.
REQ-012 SHALL have port filt_data, output, IOWidth bits: filtered pin levels.
REQ-013 SHALL have port event_flag, output, IOWidth bits: sticky edge-event flags.
REQ-014 SHALL have port irq, output, 1 bit: OR of (event_flag AND irq_mask).

Function
REQ-015 SHALL pass each pin through a 2-flop synchronizer (s1, then s2).
REQ-016 SHALL give each pin a counter cnt[FiltWidth-1:0], updated only on tick cycles.
- Without the configuration feature, every cycle is a tick.
REQ-017 SHALL apply these per-pin filter rules on each tick:
- s2 == filt_data: cnt <= 0.
- s2 != filt_data and cnt == filt_len: filt_data <= s2 and cnt <= 0.
- Otherwise: cnt <= cnt + 1.
REQ-018 SHALL give a latency of exactly 3 + filt_len cycles from a pin_in change to the filt_data change, with every cycle a tick.
- With filt_len = 0, filt_data changes on the 3rd clock edge.
REQ-019 SHALL reject any pulse shorter than filt_len + 1 ticks at s2, leaving filt_data unchanged and cnt returned to 0.
REQ-020 SHALL treat a filt_len change mid-count as taking effect on the next tick, comparing against the current cnt.
- If cnt > filt_len, counting continues and wraps modulo 2^FiltWidth; no saturation.
REQ-021 SHALL register the previous filt_data value and derive edges from it:
- rise = filt_data AND NOT prev.
- fall = NOT filt_data AND prev.
REQ-022 SHALL set event_flag[i] one cycle after the filt_data[i] transition when (rise AND rise_ena) OR (fall AND fall_ena) holds.
REQ-023 SHALL clear event_flag[i] on any cycle where event_clr[i] = 1.
- If set and clear coincide, set wins and the flag stays 1.
REQ-024 SHALL drive irq combinationally from event_flag and irq_mask, with no added latency.

Reset
REQ-025 SHALL, on the first clock edge with reset_n = 0, clear s1, s2, prev, filt_data, every cnt, event_flag and the prescale counter to 0.
- irq is therefore 0.
REQ-026 SHALL abandon any filtering in progress when reset is asserted mid-operation.
- After release, a pin held high produces a rise event once its filter completes, if rise_ena is set.

Configuration
REQ-027 SHALL implement the macro GPIO_IN_FILT_PRESCALE_EN as follows:
- Defined: a 16-bit down-counter loads prescale on reaching 0 and asserts tick for that one cycle, so a tick occurs every prescale + 1 cycles; prescale = 0 gives a tick every cycle.
- Not defined: tick is constantly 1, the prescale input is ignored and no divider logic exists.

Verification
REQ-028 SHALL cover: filt_len = 0, pin_in[0] 0->1 -> filt_data[0] = 1 on the 3rd edge; with rise_ena[0] = 1, event_flag[0] = 1 on the 4th edge.
REQ-029 SHALL cover: filt_len = 4, pin_in[5] high for 4 cycles then low -> filt_data[5] stays 0 and event_flag[5] stays 0.
- Same setup, held high for 5 cycles -> filt_data[5] = 1 on edge 7.
REQ-030 SHALL cover: event_flag[3] = 1 and irq_mask[3] = 1 -> irq = 1; event_clr[3] = 1 for one cycle -> flag and irq = 0 next edge.
REQ-031 SHALL cover: event_clr[3] = 1 on the same cycle as a new enabled edge on pin 3 -> event_flag[3] remains 1.
REQ-032 SHALL cover: fall_ena = 0, rise_ena = 1, pin goes 1 then 0 -> exactly one flag set, on the rise only.
REQ-033 SHALL cover, with GPIO_IN_FILT_PRESCALE_EN defined: prescale = 3, filt_len = 2 -> the filtered edge lags the s2 change by 3 ticks (12 cycles ±3).
- Also: reset_n = 0 mid-count -> all outputs 0 next edge.

Source files
------------

// File: rtl/gpio_in_filter.sv
// Per-pin synchronizer, glitch filter and sticky edge-event flags.
// Optional tick prescaler is compiled in with GPIO_IN_FILT_PRESCALE_EN.
module gpio_in_filter #(
  parameter int IOWidth   = 36,
  parameter int FiltWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IOWidth-1:0]   pin_in,
  input  logic [FiltWidth-1:0] filt_len,
  input  logic [15:0]          prescale,
  input  logic [IOWidth-1:0]   rise_ena,
  input  logic [IOWidth-1:0]   fall_ena,
  input  logic [IOWidth-1:0]   irq_mask,
  input  logic [IOWidth-1:0]   event_clr,
  output logic [IOWidth-1:0]   filt_data,
  output logic [IOWidth-1:0]   event_flag,
  output logic                 irq
);

  logic [IOWidth-1:0]   s1;
  logic [IOWidth-1:0]   s2;
  logic [IOWidth-1:0]   prev;
  logic [IOWidth-1:0]   filt_q;
  logic [IOWidth-1:0]   flag_q;
  logic [FiltWidth-1:0] cnt [IOWidth];

  logic                 tick;
  logic [IOWidth-1:0]   stable;
  logic [IOWidth-1:0]   expire;
  logic [IOWidth-1:0]   rise;
  logic [IOWidth-1:0]   fall;
  logic [IOWidth-1:0]   set_evt;

`ifdef GPIO_IN_FILT_PRESCALE_EN
  logic [15:0] pcnt;

  // Down-counter: reload on zero, tick on the zero cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (pcnt == 16'd0) begin
      pcnt <= prescale;
    end else begin
      pcnt <= pcnt - 16'd1;
    end
  end

  assign tick = (pcnt == 16'd0);
`else
  logic unused_prescale;

  assign unused_prescale = ^prescale;
  assign tick = 1'b1;
`endif

  // Two-flop synchronizer for the raw pin levels.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
    end
  end

  // Per-pin decode: level matches, or mismatch held long enough.
  always_comb begin
    stable = '0;
    expire = '0;
    for (int i = 0; i < IOWidth; i++) begin
      stable[i] = (s2[i] == filt_q[i]);
      expire[i] = !stable[i] && (cnt[i] == filt_len);
    end
  end

  // Filter counters; counting wraps, it never saturates.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_q <= '0;
      for (int i = 0; i < IOWidth; i++) begin
        cnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < IOWidth; i++) begin
        unique case (1'b1)
          stable[i]: begin
            cnt[i] <= '0;
          end
          expire[i]: begin
            cnt[i]    <= '0;
            filt_q[i] <= s2[i];
          end
          default: begin
            cnt[i] <= cnt[i] + FiltWidth'(1);
          end
        endcase
      end
    end
  end

  // Previous filtered level for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= filt_q;
    end
  end

  assign rise    = filt_q & ~prev;
  assign fall    = ~filt_q & prev;
  assign set_evt = (rise & rise_ena) | (fall & fall_ena);

  // Sticky flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flag_q <= '0;
    end else begin
      flag_q <= set_evt | (flag_q & ~event_clr);
    end
  end

  assign filt_data  = filt_q;
  assign event_flag = flag_q;
  assign irq        = |(flag_q & irq_mask);

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed self-checking bench for gpio_in_filter.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_gpio_in_filter;

  localparam int W  = 36;
  localparam int FW = 8;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  pin_in;
  logic [FW-1:0] filt_len;
  logic [15:0]   prescale;
  logic [W-1:0]  rise_ena;
  logic [W-1:0]  fall_ena;
  logic [W-1:0]  irq_mask;
  logic [W-1:0]  event_clr;
  logic [W-1:0]  filt_data;
  logic [W-1:0]  event_flag;
  logic          irq;

  int tests;
  int fails;

  gpio_in_filter #(
    .IOWidth(W),
    .FiltWidth(FW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pin_in(pin_in),
    .filt_len(filt_len),
    .prescale(prescale),
    .rise_ena(rise_ena),
    .fall_ena(fall_ena),
    .irq_mask(irq_mask),
    .event_clr(event_clr),
    .filt_data(filt_data),
    .event_flag(event_flag),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    event_clr = '1;
    step(30);
    event_clr = '0;
    step(1);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    pin_in    = '1;
    filt_len  = '0;
    prescale  = '0;
    rise_ena  = '1;
    fall_ena  = '1;
    irq_mask  = '1;
    event_clr = '0;
    step(2);
    tests++;
    if (filt_data !== '0) begin
      fails++;
      $display("FAIL reset_filt got=%h exp=0", filt_data);
    end
    tests++;
    if (event_flag !== '0) begin
      fails++;
      $display("FAIL reset_flag got=%h exp=0", event_flag);
    end
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    pin_in   = '0;
    rise_ena = '0;
    fall_ena = '0;
    irq_mask = '0;
    step(3);
    reset_n = 1'b1;
    step(3);
  endtask

  task automatic test_len0();
    logic exp_f;
    filt_len    = 8'd0;
    rise_ena[0] = 1'b1;
    pin_in[0]   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      exp_f = (k >= 3);
      tests++;
      if (filt_data[0] !== exp_f) begin
        fails++;
        $display("FAIL len0_filt edge=%0d got=%b exp=%b",
                 k, filt_data[0], exp_f);
      end
    end
    tests++;
    if (event_flag[0] !== 1'b1) begin
      fails++;
      $display("FAIL len0_flag got=%b exp=1", event_flag[0]);
    end
    pin_in[0] = 1'b0;
    settle();
  endtask

  task automatic test_glitch();
    int bad;
    logic exp_f;
    filt_len    = 8'd4;
    rise_ena[5] = 1'b1;
    pin_in[5]   = 1'b1;
    step(4);
    pin_in[5] = 1'b0;
    bad = 0;
    for (int k = 5; k <= 16; k++) begin
      step(1);
      if (filt_data[5] !== 1'b0 || event_flag[5] !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL glitch4 bad_cycles got=%0d exp=0", bad);
    end
    pin_in[5] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (k == 5) pin_in[5] = 1'b0;
      exp_f = (k >= 7);
      tests++;
      if (filt_data[5] !== exp_f) begin
        fails++;
        $display("FAIL held5_filt edge=%0d got=%b exp=%b",
                 k, filt_data[5], exp_f);
      end
    end
    tests++;
    if (event_flag[5] !== 1'b1) begin
      fails++;
      $display("FAIL held5_flag got=%b exp=1", event_flag[5]);
    end
    settle();
  endtask

  task automatic test_irq();
    filt_len    = 8'd0;
    rise_ena[3] = 1'b1;
    irq_mask[3] = 1'b1;
    pin_in[3]   = 1'b1;
    step(4);
    tests++;
    if (event_flag[3] !== 1'b1 || irq !== 1'b1) begin
      fails++;
      $display("FAIL irq_set got=%b/%b exp=1/1", event_flag[3], irq);
    end
    irq_mask[3] = 1'b0;
    #1;
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_masked got=%b exp=0", irq);
    end
    irq_mask[3]  = 1'b1;
    event_clr[3] = 1'b1;
    step(1);
    event_clr[3] = 1'b0;
    tests++;
    if (event_flag[3] !== 1'b0 || irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_clr got=%b/%b exp=0/0", event_flag[3], irq);
    end
  endtask

  task automatic test_set_clr();
    fall_ena[3] = 1'b1;
    pin_in[3]   = 1'b0;
    step(3);
    tests++;
    if (filt_data[3] !== 1'b0) begin
      fails++;
      $display("FAIL setclr_filt got=%b exp=0", filt_data[3]);
    end
    event_clr[3] = 1'b1;
    step(1);
    tests++;
    if (event_flag[3] !== 1'b1) begin
      fails++;
      $display("FAIL setclr_win got=%b exp=1", event_flag[3]);
    end
    step(1);
    event_clr[3] = 1'b0;
    tests++;
    if (event_flag[3] !== 1'b0) begin
      fails++;
      $display("FAIL setclr_after got=%b exp=0", event_flag[3]);
    end
    fall_ena = '0;
    rise_ena = '0;
    irq_mask = '0;
    settle();
  endtask

  task automatic test_rise_only();
    int sets;
    logic last;
    filt_len    = 8'd0;
    rise_ena[7] = 1'b1;
    fall_ena    = '0;
    pin_in[7]   = 1'b1;
    sets = 0;
    last = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k == 6) pin_in[7] = 1'b0;
      if (event_flag[7] && !last) sets++;
      last = event_flag[7];
    end
    tests++;
    if (sets != 1) begin
      fails++;
      $display("FAIL rise_only_sets got=%0d exp=1", sets);
    end
    tests++;
    if (filt_data[7] !== 1'b0) begin
      fails++;
      $display("FAIL rise_only_filt got=%b exp=0", filt_data[7]);
    end
    rise_ena = '0;
    settle();
  endtask

  task automatic test_reset_mid();
    logic exp_f;
    filt_len    = 8'd0;
    rise_ena[1] = 1'b1;
    rise_ena[9] = 1'b1;
    irq_mask    = '1;
    pin_in[1]   = 1'b1;
    step(4);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_irq got=%b exp=1", irq);
    end
    filt_len  = 8'd10;
    pin_in[9] = 1'b1;
    step(6);
    reset_n = 1'b0;
    step(1);
    tests++;
    if (filt_data !== '0 || event_flag !== '0 || irq !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got=%h/%h/%b exp=0/0/0",
               filt_data, event_flag, irq);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      if (k == 12 || k == 13) begin
        exp_f = (k == 13);
        tests++;
        if (filt_data[9] !== exp_f) begin
          fails++;
          $display("FAIL post_reset_filt edge=%0d got=%b exp=%b",
                   k, filt_data[9], exp_f);
        end
      end
    end
    tests++;
    if (event_flag[9] !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_flag got=%b exp=1", event_flag[9]);
    end
    pin_in   = '0;
    rise_ena = '0;
    irq_mask = '0;
    settle();
  endtask

`ifdef GPIO_IN_FILT_PRESCALE_EN
  task automatic test_prescale();
    int lat;
    prescale   = 16'd3;
    filt_len   = 8'd2;
    step(8);
    pin_in[12] = 1'b1;
    lat = 0;
    while (filt_data[12] !== 1'b1 && lat < 60) begin
      step(1);
      lat++;
    end
    tests++;
    if (lat < 11 || lat > 20) begin
      fails++;
      $display("FAIL prescale_lat got=%0d exp=11..20", lat);
    end
    pin_in   = '0;
    prescale = '0;
    settle();
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_len0();
    test_glitch();
    test_irq();
    test_set_clr();
    test_rise_only();
    test_reset_mid();
`ifdef GPIO_IN_FILT_PRESCALE_EN
    test_prescale();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
